branch_update_queue: RTL
========================

# branch_update_queue

In-order queue of in-flight predicted conditional branches, sitting between fetch and execute. It is the update-side driver for the global branch predictor. Fetch enqueues each predicted branch with its PC, predicted direction and predicted target. Execute resolves the oldest entry; the block then produces the registered predictor update (write, write_pc, write_value), a registered redirect on mispredict, and performance counters.

## Interface
- DEPTH, 4, queue entries; power of 2, ≥2
- CNT_WIDTH, 16, width of performance counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  external pipeline flush (exception/trap); drops all entries
- enq_valid  in  1  fetch presents a predicted conditional branch
- enq_pc  in  32  branch PC
- enq_prediction  in  1  predicted direction (1 = taken)
- enq_target  in  32  predicted taken target
- enq_ready  out  1  queue can accept; combinational, = (count != DEPTH) && !rst
- res_valid  in  1  execute resolves the oldest branch
- res_taken  in  1  actual direction
- res_target  in  32  actual computed taken target
- res_ready  out  1  oldest entry available; combinational, = (count != 0) && !rst
- upd_write  out  1  registered one-cycle pulse to predictor write
- upd_pc  out  32  registered; predictor write_pc
- upd_value  out  1  registered; predictor write_value (= res_taken)
- redirect  out  1  registered one-cycle pulse: mispredict
- redirect_pc  out  32  registered correct next PC
- branch_count  out  CNT_WIDTH  resolved branches, saturating
- mispredict_count  out  CNT_WIDTH  mispredicted branches, saturating

## Operation
- Storage: circular buffer of DEPTH entries {pc, prediction, target}; head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits.
- Enqueue fires when enq_valid && enq_ready; entry is written at the tail and tail increments.
- Resolve fires when res_valid && res_ready; it consumes the head entry.
- Mispredict = (res_taken != head.prediction) || (res_taken && res_target != head.target).
- Correct next PC = res_taken ? res_target : head.pc + 4 (32-bit wrap).
- On resolve: upd_write=1, upd_pc=head.pc, upd_value=res_taken for exactly the next cycle. branch_count increments.
- On mispredict, additionally: redirect=1 and redirect_pc=correct next PC for the next cycle; mispredict_count increments.
- Mispredicting resolve: all younger entries are wrong-path. Head, tail and count all reset to 0 at that edge. A same-cycle enqueue is discarded.
- Correct resolve with simultaneous enqueue: both occur and count is unchanged. Without enqueue, count decrements.
- flush has priority over everything. Queue empties, and any same-cycle enqueue and resolve are discarded. No upd_write, redirect or counter change results.
- res_valid while empty, and enq_valid while full, are ignored. There is no bypass: a full queue does not accept an enqueue in the same cycle as a resolve.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset: count=0, head=tail=0; upd_write=0, upd_pc=0, upd_value=0, redirect=0, redirect_pc=0, counters=0; enq_ready=res_ready=0 while rst is high. Reset mid-operation drops all entries and any pending pulses at that edge.
- Resolve in cycle N gives upd_write/redirect high in cycle N+1 only. They are low in N+2 unless another resolve occurred in N+1.
- Enqueue in cycle N gives res_ready high in cycle N+1 (from empty).
- After a mispredict in cycle N: in cycle N+1 the queue is empty, enq_ready=1 and res_ready=0.
- Back-to-back resolves at 1 per cycle are supported; upd_write stays high continuously.

## Test plan
- Reset, then enqueue pc=0x100, pred=1, tgt=0x200; resolve taken with res_target=0x200 → next cycle upd_write=1, upd_pc=0x100, upd_value=1, redirect=0; branch_count=1.
- Enqueue 0x100 pred=0, then 0x104, 0x108; resolve first as taken, target 0x40 → redirect=1, redirect_pc=0x40, mispredict_count=1; following cycle res_ready=0, count=0.
- Enqueue pc=0x10 pred=1, tgt=0x80; resolve not-taken → redirect_pc=0x14, upd_value=0.
- Fill DEPTH=4 → enq_ready=0. In the same cycle assert enq_valid and a correct resolve → the enqueue is not accepted and count becomes 3. Then four resolves in consecutive cycles drain the queue in FIFO order with upd_write high for four cycles; verify pointer wrap across ≥2 full fills.
- With 2 entries queued, assert flush together with res_valid and enq_valid → queue empty; no upd_write, no redirect, counters unchanged.
- Preload counters near saturation (CNT_WIDTH=4); perform 17 mispredicts → both counters hold 0xF.

Source files
------------

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order queue of predicted conditional branches between
// fetch and execute. It drives the global predictor's update port and raises a
// redirect when a branch was mispredicted.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         drops every entry; same-cycle enq/resolve ignored
//   enq_valid/pc/prediction/target, enq_ready   fetch-side enqueue
//   res_valid/taken/target, res_ready           execute-side resolve of the oldest entry
//   upd_write/pc/value            registered one-cycle predictor write
//   redirect, redirect_pc         registered one-cycle mispredict redirect
//   branch_count, mispredict_count  saturating performance counters
module branch_update_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 enq_valid,
    input  logic [31:0]          enq_pc,
    input  logic                 enq_prediction,
    input  logic [31:0]          enq_target,
    output logic                 enq_ready,
    input  logic                 res_valid,
    input  logic                 res_taken,
    input  logic [31:0]          res_target,
    output logic                 res_ready,
    output logic                 upd_write,
    output logic [31:0]          upd_pc,
    output logic                 upd_value,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage
    logic [31:0]      r_pc   [DEPTH];
    logic             r_pred [DEPTH];
    logic [31:0]      r_tgt  [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq_fire;
    logic             w_res_fire;
    logic             w_mispredict;
    logic             w_enq_write;
    logic [31:0]      w_head_pc;
    logic             w_head_pred;
    logic [31:0]      w_head_tgt;
    logic [31:0]      w_next_pc;

    assign enq_ready = (r_count != CNT_W'(DEPTH)) && !rst;
    assign res_ready = (r_count != CNT_W'(0)) && !rst;

    assign w_head_pc   = r_pc[r_head];
    assign w_head_pred = r_pred[r_head];
    assign w_head_tgt  = r_tgt[r_head];

    assign w_enq_fire = enq_valid && enq_ready;
    assign w_res_fire = res_valid && res_ready;

    // A taken branch is also wrong when it went somewhere other than predicted
    assign w_mispredict = w_res_fire &&
                          ((res_taken != w_head_pred) ||
                           (res_taken && (res_target != w_head_tgt)));

    assign w_next_pc = res_taken ? res_target : (w_head_pc + 32'd4);

    // Enqueue is dropped on flush and on a mispredict (it is wrong-path)
    assign w_enq_write = w_enq_fire && !flush && !w_mispredict;

    // Entry payload write; no reset needed, validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_enq_write) begin
            r_pc[r_tail]   <= enq_pc;
            r_pred[r_tail] <= enq_prediction;
            r_tgt[r_tail]  <= enq_target;
        end
    end

    // Pointers, occupancy, update/redirect pulses and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            upd_write        <= 1'b0;
            upd_pc           <= '0;
            upd_value        <= 1'b0;
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            upd_write <= 1'b0;
            redirect  <= 1'b0;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_res_fire) begin
                    upd_write <= 1'b1;
                    upd_pc    <= w_head_pc;
                    upd_value <= res_taken;
                    if (branch_count != {CNT_WIDTH{1'b1}}) begin
                        branch_count <= branch_count + CNT_WIDTH'(1);
                    end
                end
                if (w_mispredict) begin
                    redirect    <= 1'b1;
                    redirect_pc <= w_next_pc;
                    if (mispredict_count != {CNT_WIDTH{1'b1}}) begin
                        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
                    end
                    // Everything younger than the head is wrong-path
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_res_fire) begin
                        r_head <= r_head + PTR_W'(1);
                    end
                    if (w_enq_write) begin
                        r_tail <= r_tail + PTR_W'(1);
                    end
                    if (w_enq_write && !w_res_fire) begin
                        r_count <= r_count + CNT_W'(1);
                    end else if (!w_enq_write && w_res_fire) begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
